// File: rtl/display_list_seq.sv
// Display-list sequencer: replays a double-banked command list to the vector
// control block once per frame, paced by ctl_ready, with frame-aligned bank swaps.
module display_list_seq #(
  parameter int ADDR_W       = 10,
  parameter int FRAME_CYCLES = 833333,
  parameter int TIMER_W      = 24
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_swap_req,
  output logic              o_swap_ack,
  output logic              o_bank,
  output logic [ADDR_W:0]   o_mem_addr,
  output logic              o_mem_rd,
  input  logic [25:0]       i_mem_data,
  input  logic              i_ctl_ready,
  output logic [11:0]       o_ctl_x,
  output logic [11:0]       o_ctl_y,
  output logic              o_ctl_jump,
  output logic              o_ctl_draw,
  output logic              o_frame_start,
  output logic              o_busy,
  output logic              o_err_overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_FRAME, S_FETCH, S_WAIT_DATA,
    S_DECODE, S_WAIT_READY, S_ISSUE, S_GUARD
  } state_t;

  localparam logic [TIMER_W-1:0] TIMER_TC = TIMER_W'(FRAME_CYCLES - 1);
  localparam logic [ADDR_W-1:0]  IDX_LAST = {ADDR_W{1'b1}};
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_DRAW = 2'b10;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_index;
  logic [TIMER_W-1:0]  r_timer;
  logic [25:0]         r_cmd;
  logic                r_swap_pend;
  logic                r_guard;
  logic                r_swap_ack;
  logic                r_bank;
  logic [ADDR_W:0]     r_mem_addr;
  logic                r_mem_rd;
  logic [11:0]         r_ctl_x;
  logic [11:0]         r_ctl_y;
  logic                r_ctl_jump;
  logic                r_ctl_draw;
  logic                r_frame_start;
  logic                r_busy;
  logic                r_err_overrun;

  logic                w_swap_pend;
  logic                w_timer_done;
  logic                w_new_bank;
  logic                w_idx_last;
  logic                w_boundary;
  logic [1:0]          w_op;
  logic [ADDR_W-1:0]   w_next_index;

  // A request arriving in the boundary cycle itself still takes effect there.
  assign w_swap_pend  = r_swap_pend | i_swap_req;
  assign w_timer_done = (r_timer == TIMER_TC);
  assign w_new_bank   = r_bank ^ w_swap_pend;
  assign w_idx_last   = (r_index == IDX_LAST);
  assign w_op         = r_cmd[25:24];
  assign w_next_index = r_index + 1'b1;
  assign w_boundary   = i_enable &&
                        ((r_state == S_IDLE) || (r_state == S_WAIT_FRAME && w_timer_done));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_index       <= '0;
      r_timer       <= '0;
      r_cmd         <= '0;
      r_swap_pend   <= 1'b0;
      r_guard       <= 1'b0;
      r_swap_ack    <= 1'b0;
      r_bank        <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_rd      <= 1'b0;
      r_ctl_x       <= '0;
      r_ctl_y       <= '0;
      r_ctl_jump    <= 1'b0;
      r_ctl_draw    <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_mem_rd      <= 1'b0;
      r_ctl_jump    <= 1'b0;
      r_ctl_draw    <= 1'b0;
      r_frame_start <= 1'b0;
      r_swap_ack    <= 1'b0;
      r_swap_pend   <= w_swap_pend;
      if (!w_timer_done)
        r_timer <= r_timer + 1'b1;

      if (w_boundary) begin
        r_state       <= S_FETCH;
        r_index       <= '0;
        r_timer       <= '0;
        r_frame_start <= 1'b1;
        r_busy        <= 1'b1;
        r_swap_pend   <= 1'b0;
        r_swap_ack    <= w_swap_pend;
        r_bank        <= w_new_bank;
        r_mem_rd      <= 1'b1;
        r_mem_addr    <= {w_new_bank, {ADDR_W{1'b0}}};
      end else begin
        case (r_state)
          S_IDLE: ;
          S_WAIT_FRAME: begin
            if (w_timer_done) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          S_FETCH: r_state <= S_WAIT_DATA;
          S_WAIT_DATA: begin
            r_cmd   <= i_mem_data;
            r_state <= S_DECODE;
          end
          S_DECODE: begin
            case (w_op)
              OP_NOP: begin
                if (w_idx_last) begin
                  r_err_overrun <= 1'b1;
                  r_state       <= S_WAIT_FRAME;
                end else begin
                  r_index    <= w_next_index;
                  r_mem_rd   <= 1'b1;
                  r_mem_addr <= {r_bank, w_next_index};
                  r_state    <= S_FETCH;
                end
              end
              OP_JUMP, OP_DRAW: begin
                r_ctl_x <= r_cmd[23:12];
                r_ctl_y <= r_cmd[11:0];
                r_state <= S_WAIT_READY;
              end
              default: r_state <= S_WAIT_FRAME;
            endcase
          end
          S_WAIT_READY: begin
            if (i_ctl_ready) begin
              r_ctl_jump <= (w_op == OP_JUMP);
              r_ctl_draw <= (w_op == OP_DRAW);
              r_state    <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            // The last word of a bank ends the frame even when it is not END.
            if (w_idx_last) begin
              r_err_overrun <= 1'b1;
              r_state       <= S_WAIT_FRAME;
            end else begin
              r_index <= w_next_index;
              r_guard <= 1'b0;
              r_state <= S_GUARD;
            end
          end
          S_GUARD: begin
            if (r_guard) begin
              r_mem_rd   <= 1'b1;
              r_mem_addr <= {r_bank, r_index};
              r_state    <= S_FETCH;
            end else begin
              r_guard <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_swap_ack    = r_swap_ack;
  assign o_bank        = r_bank;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_rd      = r_mem_rd;
  assign o_ctl_x       = r_ctl_x;
  assign o_ctl_y       = r_ctl_y;
  assign o_ctl_jump    = r_ctl_jump;
  assign o_ctl_draw    = r_ctl_draw;
  assign o_frame_start = r_frame_start;
  assign o_busy        = r_busy;
  assign o_err_overrun = r_err_overrun;

endmodule

// File: tb/tb_display_list_seq.sv
// Directed bench for display_list_seq: 8-word banks, 64-cycle frames,
// table of bank-0 commands with expected pulses plus hand-timed corner sequences.
module tb_display_list_seq;
  localparam int AW = 3;
  localparam int FC = 64;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, swap_req = 1'b0, ctl_ready = 1'b1;
  logic swap_ack, bank, mem_rd, ctl_jump, ctl_draw, frame_start, busy, err_overrun;
  logic [AW:0]  mem_addr;
  logic [25:0]  mem_data = '0;
  logic [11:0]  ctl_x, ctl_y;
  logic [25:0]  mem [0:15];
  int n_vec = 0, n_err = 0, cyc = 0, n_ack = 0;

  display_list_seq #(.ADDR_W(AW), .FRAME_CYCLES(FC), .TIMER_W(TW)) dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_swap_req(swap_req),
    .o_swap_ack(swap_ack), .o_bank(bank), .o_mem_addr(mem_addr), .o_mem_rd(mem_rd),
    .i_mem_data(mem_data), .i_ctl_ready(ctl_ready), .o_ctl_x(ctl_x), .o_ctl_y(ctl_y),
    .o_ctl_jump(ctl_jump), .o_ctl_draw(ctl_draw), .o_frame_start(frame_start),
    .o_busy(busy), .o_err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  typedef struct {int c; logic draw; logic [11:0] x; logic [11:0] y;} ev_t;
  ev_t evq[$];

  always @(negedge clk) begin
    if (ctl_jump || ctl_draw) evq.push_back('{cyc, ctl_draw, ctl_x, ctl_y});
    if (swap_ack) n_ack = n_ack + 1;
    if (ctl_jump && ctl_draw) begin
      n_err = n_err + 1;
      $display("FAIL pulse_excl: jump=1 draw=1 together at cycle %0d, required not both", cyc);
    end
  end

  typedef struct {
    logic [25:0] word; logic pulse; logic draw; logic [11:0] x; logic [11:0] y; int gap;
  } vec_t;
  vec_t prog [5];

  function automatic logic [25:0] cmd(input logic [1:0] op, input logic [11:0] x,
                                      input logic [11:0] y);
    return {op, x, y};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_fs(input int limit, output int at, output int nrd);
    at = -1;
    nrd = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (frame_start) begin
        at = cyc;
        break;
      end
      if (mem_rd) nrd++;
    end
    if (at < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_start_timeout: none within %0d cycles", limit);
    end
  endtask

  // Walks the program table against captured pulses; gap is from the previous pulse.
  task automatic check_frame(input string tag, input int ref_cyc, input int base,
                             input int first_gap);
    int prev;
    int k;
    int g;
    prev = ref_cyc;
    k = base;
    for (int i = 0; i < 5; i++) begin
      if (prog[i].pulse) begin
        g = (k == base) ? first_gap : prog[i].gap;
        if (k >= evq.size()) begin
          n_vec++;
          n_err++;
          $display("FAIL %s_missing: pulse %0d absent, required present", tag, k - base);
        end else begin
          chk({tag, "_kind"}, 64'(evq[k].draw), 64'(prog[i].draw));
          chk({tag, "_x"}, 64'(evq[k].x), 64'(prog[i].x));
          chk({tag, "_y"}, 64'(evq[k].y), 64'(prog[i].y));
          chk({tag, "_gap"}, 64'(evq[k].c - prev), 64'(g));
          prev = evq[k].c;
        end
        k++;
      end
    end
  endtask

  int f1, f2, f3, f4, f5, f6, f7, f8, f9, nrd, tr, b, fall, nfs;

  initial begin
    prog[0] = '{cmd(2'b01, 12'd100, 12'd200), 1'b1, 1'b0, 12'd100, 12'd200, 4};
    prog[1] = '{cmd(2'b10, 12'd300, 12'd400), 1'b1, 1'b1, 12'd300, 12'd400, 7};
    prog[2] = '{cmd(2'b00, 12'd0, 12'd0), 1'b0, 1'b0, 12'd0, 12'd0, 0};
    prog[3] = '{cmd(2'b10, 12'hABC, 12'h123), 1'b1, 1'b1, 12'hABC, 12'h123, 10};
    prog[4] = '{cmd(2'b11, 12'd0, 12'd0), 1'b0, 1'b0, 12'd0, 12'd0, 0};
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int i = 0; i < 5; i++) mem[i] = prog[i].word;
    mem[8] = cmd(2'b10, 12'd7, 12'd7);
    mem[9] = cmd(2'b11, 12'd0, 12'd0);

    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({swap_ack, bank, mem_addr, mem_rd, ctl_x, ctl_y, ctl_jump,
                              ctl_draw, frame_start, busy, err_overrun}), 64'd0);
    reset = 1'b0;
    enable = 1'b1;

    // Basic frame with ready tied high
    wait_fs(20, f1, nrd);
    chk("f1_bank", 64'(bank), 64'd0);
    chk("f1_addr", 64'(mem_addr), 64'd0);
    chk("f1_rd", 64'(mem_rd), 64'd1);
    chk("f1_busy", 64'(busy), 64'd1);
    wait_fs(200, f2, nrd);
    chk("frame_period", 64'(f2 - f1), 64'(FC));
    chk("f1_count", 64'(evq.size()), 64'd3);
    check_frame("f1", f1, 0, 4);

    // Ready held low across the first command of frame 2
    ctl_ready = 1'b0;
    b = evq.size();
    repeat (50) @(negedge clk);
    chk("ready_low_no_pulse", 64'(evq.size()), 64'(b));
    tr = cyc;
    ctl_ready = 1'b1;
    wait_fs(200, f3, nrd);
    chk("f2_count", 64'(evq.size() - b), 64'd3);
    check_frame("f2", tr, b, 1);
    if (evq.size() > 0) chk("late_end_restart", 64'(f3 - evq[evq.size() - 1].c), 64'd7);

    // Two swap requests mid-frame 3
    b = evq.size();
    repeat (10) @(negedge clk);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    repeat (5) @(negedge clk);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    wait_fs(200, f4, nrd);
    chk("f3_period", 64'(f4 - f3), 64'(FC));
    chk("f3_count", 64'(evq.size() - b), 64'd3);
    chk("swap_ack_at_fs", 64'(swap_ack), 64'd1);
    chk("swap_bank", 64'(bank), 64'd1);
    chk("swap_addr_msb", 64'(mem_addr[AW]), 64'd1);

    // Swap requested in the boundary cycle itself
    b = evq.size();
    repeat (63) @(negedge clk);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    f5 = cyc;
    chk("f5_start", 64'(frame_start), 64'd1);
    chk("f4_period", 64'(f5 - f4), 64'(FC));
    chk("boundary_swap_ack", 64'(swap_ack), 64'd1);
    chk("boundary_swap_bank", 64'(bank), 64'd0);
    chk("f4_count", 64'(evq.size() - b), 64'd1);
    if (evq.size() > b) begin
      chk("f4_draw", 64'(evq[b].draw), 64'd1);
      chk("f4_xy", 64'({evq[b].x, evq[b].y}), 64'({12'd7, 12'd7}));
      chk("f4_gap", 64'(evq[b].c - f4), 64'd4);
    end

    // Bank 1 becomes all NOPs; run it to overrun
    for (int i = 8; i < 16; i++) mem[i] = '0;
    repeat (5) @(negedge clk);
    chk("ack_total", 64'(n_ack), 64'd2);
    chk("err_before", 64'(err_overrun), 64'd0);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    wait_fs(200, f6, nrd);
    chk("f5_period", 64'(f6 - f5), 64'(FC));
    chk("f6_bank", 64'(bank), 64'd1);
    b = evq.size();
    wait_fs(200, f7, nrd);
    chk("overrun_reads", 64'(nrd), 64'd7);   // first fetch was at frame_start
    chk("overrun_flag", 64'(err_overrun), 64'd1);
    chk("overrun_no_pulse", 64'(evq.size() - b), 64'd0);
    chk("overrun_period", 64'(f7 - f6), 64'(FC));
    chk("overrun_restart_addr", 64'(mem_addr), 64'd8);

    // Back to bank 0, then drop enable mid-frame
    repeat (5) @(negedge clk);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    wait_fs(200, f8, nrd);
    chk("f8_bank", 64'(bank), 64'd0);
    b = evq.size();
    repeat (5) @(negedge clk);
    enable = 1'b0;
    fall = -1;
    nfs = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_start) nfs++;
      if (!busy) begin
        fall = cyc;
        break;
      end
    end
    chk("busy_fall", 64'(fall - f8), 64'(FC));
    chk("no_restart", 64'(nfs), 64'd0);
    chk("f8_count", 64'(evq.size() - b), 64'd3);
    check_frame("f8", f8, b, 4);
    repeat (5) @(negedge clk);
    chk("idle_quiet", 64'({busy, frame_start, mem_rd}), 64'd0);

    // Reset while parked in WAIT_READY
    ctl_ready = 1'b0;
    enable = 1'b1;
    wait_fs(10, f9, nrd);
    b = evq.size();
    repeat (6) @(negedge clk);
    chk("pre_reset_xy", 64'({ctl_x, ctl_y}), 64'({12'd100, 12'd200}));
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk("reset_wait_ready", 64'({swap_ack, bank, mem_addr, mem_rd, ctl_x, ctl_y, ctl_jump,
                                 ctl_draw, frame_start, busy, err_overrun}), 64'd0);
    reset = 1'b0;
    ctl_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_idle", 64'({busy, frame_start, mem_rd}), 64'd0);
    chk("reset_no_pulse", 64'(evq.size() - b), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
